tlc_monitor: RTL and testbench

//  Receive-side checker for the traffic-light lamp interface (red/yellow/green).

---
 rtl/tlc_monitor.sv | 158 +++++++++++++++
 tb/tb_tlc_monitor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_monitor.sv
// Receive-side checker for a red/yellow/green lamp interface: phase decode, dwell and order checks, sticky fault.
// Optional build macro TLC_MON_ERR_CNT_EN adds an 8-bit saturating err_count of FAULT entries.
module tlc_monitor #(
   parameter int DW_W       = 8,
   parameter int CNT_W      = 8,
   parameter int MIN_RED    = 1,
   parameter int MIN_GREEN  = 1,
   parameter int MIN_YELLOW = 1,
   parameter int MAX_DWELL  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             red,
   input  logic             yellow,
   input  logic             green,
   input  logic             clr_fault,
   output logic [1:0]       phase,
   output logic [DW_W-1:0]  dwell,
   output logic [CNT_W-1:0] cycle_count,
   output logic             fault,
   output logic [2:0]       fault_code
`ifdef TLC_MON_ERR_CNT_EN
   ,
   output logic [7:0]       err_count
`endif
);

   typedef enum logic [1:0] {ST_SYNC, ST_RUN, ST_FAULT} state_t;

   localparam logic [1:0] PH_RED    = 2'b00;
   localparam logic [1:0] PH_GREEN  = 2'b01;
   localparam logic [1:0] PH_YELLOW = 2'b10;
   localparam logic [1:0] PH_NONE   = 2'b11;

   localparam logic [2:0] FC_NONE    = 3'b000;
   localparam logic [2:0] FC_MULTI   = 3'b001;
   localparam logic [2:0] FC_DARK    = 3'b010;
   localparam logic [2:0] FC_ILLEGAL = 3'b011;
   localparam logic [2:0] FC_SHORT   = 3'b100;
   localparam logic [2:0] FC_STUCK   = 3'b101;

   logic [2:0]       lamps_q;
   state_t           state, state_d;
   logic [1:0]       phase_d;
   logic [DW_W-1:0]  dwell_d;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       code_d;

   logic             multi_hot, dark;
   logic [1:0]       lamp_ph, succ;
   logic [DW_W-1:0]  min_dw, dwell_inc;

   // State register; lamps are registered once and every check works on lamps_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         lamps_q     <= 3'b000;
         state       <= ST_SYNC;
         phase       <= PH_NONE;
         dwell       <= '0;
         cycle_count <= '0;
         fault_code  <= FC_NONE;
      end else begin
         lamps_q     <= {red, yellow, green};
         state       <= state_d;
         phase       <= phase_d;
         dwell       <= dwell_d;
         cycle_count <= cnt_d;
         fault_code  <= code_d;
      end
   end

   always_comb begin
      multi_hot = (lamps_q[2] & lamps_q[1]) | (lamps_q[2] & lamps_q[0]) | (lamps_q[1] & lamps_q[0]);
      dark      = (lamps_q == 3'b000);
      case (lamps_q)
         3'b100:  lamp_ph = PH_RED;
         3'b001:  lamp_ph = PH_GREEN;
         3'b010:  lamp_ph = PH_YELLOW;
         default: lamp_ph = PH_NONE;
      endcase
      case (phase)
         PH_RED:    begin succ = PH_GREEN;  min_dw = DW_W'(MIN_RED);    end
         PH_GREEN:  begin succ = PH_YELLOW; min_dw = DW_W'(MIN_GREEN);  end
         PH_YELLOW: begin succ = PH_RED;    min_dw = DW_W'(MIN_YELLOW); end
         default:   begin succ = PH_NONE;   min_dw = '0;                end
      endcase
      dwell_inc = (&dwell) ? dwell : dwell + 1'b1;
   end

   // Next-state: in RUN the checks are prioritised multi-hot, dark, same lamp, transition.
   always_comb begin
      state_d = state;
      phase_d = phase;
      dwell_d = dwell;
      cnt_d   = cycle_count;
      code_d  = fault_code;
      case (state)
         ST_SYNC: begin
            if (multi_hot) begin
               state_d = ST_FAULT;
               code_d  = FC_MULTI;
            end else if (lamps_q == 3'b100) begin
               state_d = ST_RUN;
               phase_d = PH_RED;
               dwell_d = DW_W'(1);
            end
         end
         ST_RUN: begin
            if (multi_hot) begin
               state_d = ST_FAULT;
               code_d  = FC_MULTI;
            end else if (dark) begin
               state_d = ST_FAULT;
               code_d  = FC_DARK;
            end else if (lamp_ph == phase) begin
               dwell_d = dwell_inc;
               if (dwell_inc == DW_W'(MAX_DWELL)) begin
                  state_d = ST_FAULT;
                  code_d  = FC_STUCK;
               end
            end else if (lamp_ph != succ) begin
               state_d = ST_FAULT;
               code_d  = FC_ILLEGAL;
            end else if (dwell < min_dw) begin
               state_d = ST_FAULT;
               code_d  = FC_SHORT;
            end else begin
               phase_d = lamp_ph;
               dwell_d = DW_W'(1);
               if (phase == PH_YELLOW) cnt_d = cycle_count + 1'b1;
            end
         end
         ST_FAULT: begin
            if (clr_fault) begin
               state_d = ST_SYNC;
               phase_d = PH_NONE;
               dwell_d = '0;
               code_d  = FC_NONE;
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   always_comb begin
      fault = (state == ST_FAULT);
   end

`ifdef TLC_MON_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         err_count <= 8'd0;
      else if (state != ST_FAULT && state_d == ST_FAULT && err_count != 8'hFF)
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_tlc_monitor.sv
// Table-driven bench for tlc_monitor: rows of {lamps, clr_fault, expected outputs}, expectations
// queued at drive time and compared two clocks later when the monitor's response appears.
module tb_tlc_monitor;

   localparam int DW_W  = 8;
   localparam int CNT_W = 8;
   localparam int EXP_W = 1 + 2 + DW_W + CNT_W + 1 + 3;

   localparam logic [2:0] L_OFF = 3'b000;
   localparam logic [2:0] L_R   = 3'b100;
   localparam logic [2:0] L_Y   = 3'b010;
   localparam logic [2:0] L_G   = 3'b001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, red, yellow, green, clr_fault;
   logic [1:0]       phase, phase_g3;
   logic [DW_W-1:0]  dwell, dwell_g3;
   logic [CNT_W-1:0] cycle_count, cycle_count_g3;
   logic             fault, fault_g3;
   logic [2:0]       fault_code, fault_code_g3;
`ifdef TLC_MON_ERR_CNT_EN
   logic [7:0]       err_count, err_count_g3;
`endif

   tlc_monitor dut (
      .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green), .clr_fault(clr_fault),
      .phase(phase), .dwell(dwell), .cycle_count(cycle_count), .fault(fault), .fault_code(fault_code)
`ifdef TLC_MON_ERR_CNT_EN
      , .err_count(err_count)
`endif
   );

   tlc_monitor #(.MIN_GREEN(3)) dut_g3 (
      .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green), .clr_fault(clr_fault),
      .phase(phase_g3), .dwell(dwell_g3), .cycle_count(cycle_count_g3), .fault(fault_g3),
      .fault_code(fault_code_g3)
`ifdef TLC_MON_ERR_CNT_EN
      , .err_count(err_count_g3)
`endif
   );

   typedef struct {
      logic [2:0]       lamps;
      logic             clr;
      logic [1:0]       ph;
      logic [DW_W-1:0]  dw;
      logic [CNT_W-1:0] cc;
      logic             flt;
      logic [2:0]       code;
   } vec_t;

   vec_t             vecs[$];
   logic [EXP_W-1:0] exp_q[$];
   string            name_q[$];
   int               n_vec = 0;
   int               n_err = 0;
   logic             clr_pend;
   logic             use_g3;

   function automatic void add(input logic [2:0] l, input logic c, input logic [1:0] ph,
                               input int dw, input int cc, input logic f, input logic [2:0] code);
      vec_t v;
      v.lamps = l;
      v.clr   = c;
      v.ph    = ph;
      v.dw    = DW_W'(dw);
      v.cc    = CNT_W'(cc);
      v.flt   = f;
      v.code  = code;
      vecs.push_back(v);
   endfunction

   task automatic check_out(input string name, input logic [EXP_W-2:0] e);
      logic [EXP_W-2:0] a;
      a = use_g3 ? {phase_g3, dwell_g3, cycle_count_g3, fault_g3, fault_code_g3}
                 : {phase, dwell, cycle_count, fault, fault_code};
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got ph=%b dw=%0d cc=%0d flt=%b code=%b, want ph=%b dw=%0d cc=%0d flt=%b code=%b",
                  name, a[21:20], a[19:12], a[11:4], a[3], a[2:0],
                  e[21:20], e[19:12], e[11:4], e[3], e[2:0]);
      end
   endtask

   // A row's clr_fault is driven one clock after its lamps so both reach the FSM on the same edge.
   task automatic step(input logic [2:0] l, input logic c, input logic chk,
                       input logic [EXP_W-2:0] e, input string name);
      logic [EXP_W-1:0] x;
      string            nm;
      if (exp_q.size() == 2) begin
         x  = exp_q.pop_front();
         nm = name_q.pop_front();
         if (x[EXP_W-1]) check_out(nm, x[EXP_W-2:0]);
      end
      {red, yellow, green} = l;
      clr_fault = clr_pend;
      clr_pend  = c;
      exp_q.push_back({chk, e});
      name_q.push_back(name);
      @(negedge clk);
   endtask

   task automatic run_table(input string tag);
      logic [2:0] last;
      foreach (vecs[i])
         step(vecs[i].lamps, vecs[i].clr, 1'b1,
              {vecs[i].ph, vecs[i].dw, vecs[i].cc, vecs[i].flt, vecs[i].code},
              $sformatf("%s[%0d]", tag, i));
      last = vecs[vecs.size()-1].lamps;
      repeat (2) step(last, 1'b0, 1'b0, '0, "flush");
      vecs.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      {red, yellow, green} = L_OFF;
      clr_fault = 1'b0;
      clr_pend  = 1'b0;
      exp_q.delete();
      name_q.delete();
      @(negedge clk);
      check_out("reset", {2'b11, 8'd0, 8'd0, 1'b0, 3'b000});
`ifdef TLC_MON_ERR_CNT_EN
      n_vec++;
      if (err_count !== 8'd0) begin
         n_err++;
         $display("FAIL err_count_reset: got %0d want 0", err_count);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      use_g3 = 1'b0;

      // Sync ignores dark/green/yellow, three full cycles, then multi-hot fault that holds.
      do_reset();
      add(L_OFF, 0, 2'b11, 0, 0, 0, 3'b000);
      add(L_G,   0, 2'b11, 0, 0, 0, 3'b000);
      add(L_Y,   0, 2'b11, 0, 0, 0, 3'b000);
      for (int k = 0; k < 3; k++) begin
         add(L_R, 0, 2'b00, 1, k, 0, 3'b000);
         add(L_G, 0, 2'b01, 1, k, 0, 3'b000);
         add(L_Y, 0, 2'b10, 1, k, 0, 3'b000);
      end
      add(L_R,    0, 2'b00, 1, 3, 0, 3'b000);
      add(L_R,    0, 2'b00, 2, 3, 0, 3'b000);
      add(L_R,    0, 2'b00, 3, 3, 0, 3'b000);
      add(L_G,    0, 2'b01, 1, 3, 0, 3'b000);
      add(L_G,    0, 2'b01, 2, 3, 0, 3'b000);
      add(L_Y,    0, 2'b10, 1, 3, 0, 3'b000);
      add(3'b101, 0, 2'b10, 1, 3, 1, 3'b001);
      add(L_R,    0, 2'b10, 1, 3, 1, 3'b001);
      add(L_G,    0, 2'b10, 1, 3, 1, 3'b001);
      add(L_Y,    0, 2'b10, 1, 3, 1, 3'b001);
      add(L_R,    0, 2'b10, 1, 3, 1, 3'b001);
      run_table("cycle");

      // Illegal transition, clear, relock; clr in RUN is ignored; fault with clr still faults.
      do_reset();
      add(L_R,    0, 2'b00, 1, 0, 0, 3'b000);
      add(L_G,    0, 2'b01, 1, 0, 0, 3'b000);
      add(L_Y,    0, 2'b10, 1, 0, 0, 3'b000);
      add(L_R,    0, 2'b00, 1, 1, 0, 3'b000);
      add(L_Y,    0, 2'b00, 1, 1, 1, 3'b011);
      add(L_OFF,  0, 2'b00, 1, 1, 1, 3'b011);
      add(L_OFF,  1, 2'b11, 0, 1, 0, 3'b000);
      add(L_G,    0, 2'b11, 0, 1, 0, 3'b000);
      add(L_R,    0, 2'b00, 1, 1, 0, 3'b000);
      add(L_R,    1, 2'b00, 2, 1, 0, 3'b000);
      add(3'b011, 1, 2'b00, 2, 1, 1, 3'b001);
      add(L_R,    1, 2'b11, 0, 1, 0, 3'b000);
      add(3'b110, 0, 2'b11, 0, 1, 1, 3'b001);
      add(L_OFF,  1, 2'b11, 0, 1, 0, 3'b000);
      run_table("clr");
`ifdef TLC_MON_ERR_CNT_EN
      n_vec++;
      if (err_count !== 8'd3) begin
         n_err++;
         $display("FAIL err_count: got %0d want 3", err_count);
      end
`endif

      // Stuck GREEN: dwell 15 is legal, dwell 16 faults.
      do_reset();
      add(L_R, 0, 2'b00, 1, 0, 0, 3'b000);
      for (int i = 1; i <= 16; i++)
         add(L_G, 0, 2'b01, i, 0, (i == 16), (i == 16) ? 3'b101 : 3'b000);
      run_table("stuck");

      // Dark lamps in RUN.
      do_reset();
      add(L_R,   0, 2'b00, 1, 0, 0, 3'b000);
      add(L_R,   0, 2'b00, 2, 0, 0, 3'b000);
      add(L_OFF, 0, 2'b00, 2, 0, 1, 3'b010);
      add(L_G,   0, 2'b00, 2, 0, 1, 3'b010);
      run_table("dark");

      // MIN_GREEN=3 instance: 2-clock green is short, 3-clock green is legal.
      use_g3 = 1'b1;
      do_reset();
      add(L_R, 0, 2'b00, 1, 0, 0, 3'b000);
      add(L_G, 0, 2'b01, 1, 0, 0, 3'b000);
      add(L_G, 0, 2'b01, 2, 0, 0, 3'b000);
      add(L_Y, 0, 2'b01, 2, 0, 1, 3'b100);
      add(L_R, 0, 2'b01, 2, 0, 1, 3'b100);
      run_table("short");
      do_reset();
      add(L_R, 0, 2'b00, 1, 0, 0, 3'b000);
      add(L_G, 0, 2'b01, 1, 0, 0, 3'b000);
      add(L_G, 0, 2'b01, 2, 0, 0, 3'b000);
      add(L_G, 0, 2'b01, 3, 0, 0, 3'b000);
      add(L_Y, 0, 2'b10, 1, 0, 0, 3'b000);
      add(L_R, 0, 2'b00, 1, 1, 0, 3'b000);
      run_table("mingreen");
      use_g3 = 1'b0;

      // Five cycles, then rst asserted mid-RUN must restore every output.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         add(L_R, 0, 2'b00, 1, k, 0, 3'b000);
         add(L_G, 0, 2'b01, 1, k, 0, 3'b000);
         add(L_Y, 0, 2'b10, 1, k, 0, 3'b000);
      end
      add(L_R, 0, 2'b00, 1, 5, 0, 3'b000);
      add(L_R, 0, 2'b00, 2, 5, 0, 3'b000);
      run_table("cnt5");
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
